// File: rtl/final385_soc_pio_gen2.sv
// Avalon-MM parallel I/O port with set/clear output access and a synchronized input.
// Define FINAL385_PIO_IRQ_EN to build in edge capture, IRQ_MASK, EDGE_CAP and irq.
module final385_soc_pio_gen2 #(
    parameter int          WIDTH       = 2,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [31:0]      rd;

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];

    always_comb begin
        data_out_d = data_out_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA_OUT: data_out_d = wd;
                ADDR_OUTSET:   data_out_d = data_out_q | wd;
                ADDR_OUTCLEAR: data_out_d = data_out_q & ~wd;
                default:       data_out_d = data_out_q;
            endcase
        end
    end

    assign s1_d = in_port;
    assign s2_d = s1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= RST_VAL;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            data_out_q <= data_out_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_port = data_out_q;

`ifdef FINAL385_PIO_IRQ_EN
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr_bits;

    assign s3_d = s2_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_hit = s2_q & ~s3_q;
            1:       edge_hit = ~s2_q & s3_q;
            default: edge_hit = s2_q ^ s3_q;
        endcase
    end

    // A fresh edge is OR-ed in after the W1C mask, so set beats clear on the same bit.
    always_comb begin
        clr_bits = '0;
        mask_d   = mask_q;
        if (wr_en && address == ADDR_EDGE_CAP) clr_bits = wd;
        if (wr_en && address == ADDR_IRQ_MASK) mask_d = wd;
        cap_d = (cap_q & ~clr_bits) | edge_hit;
        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_q   <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            s3_q   <= s3_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA_OUT: rd[WIDTH-1:0] = data_out_q;
            ADDR_DATA_IN:  rd[WIDTH-1:0] = s2_q;
            ADDR_IRQ_MASK: rd[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: rd[WIDTH-1:0] = cap_q;
            default:       rd = '0;
        endcase
    end
`else
    assign irq = 1'b0;

    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA_OUT: rd[WIDTH-1:0] = data_out_q;
            ADDR_DATA_IN:  rd[WIDTH-1:0] = s2_q;
            default:       rd = '0;
        endcase
    end
`endif

    assign readdata = rd;

    // Upper writedata bits are architecturally ignored.
    logic unused_ok;
    assign unused_ok = ^writedata;

endmodule

// File: tb/tb_final385_soc_pio_gen2.sv
// Directed self-checking bench for final385_soc_pio_gen2 (WIDTH=8, RESET_VALUE=8'hA5, rising edges).
// Exercises the IRQ block when FINAL385_PIO_IRQ_EN is defined, else the disabled-feature behavior.
module tb_final385_soc_pio_gen2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  in_port = 8'h00;
    logic [7:0]  out_port;
    logic        irq;

    int total = 0;
    int bad = 0;

    final385_soc_pio_gen2 #(
        .WIDTH(8),
        .RESET_VALUE(32'h0000_00A5),
        .EDGE_TYPE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .out_port(out_port),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        address = 3'd0;
        #1;
        total++; if (out_port !== 8'hA5) begin bad++; $display("[TB] FAIL reset_out: got %h expected a5", out_port); end
        total++; if (readdata !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL reset_rd0: got %h expected 000000a5", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        address = 3'd2; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_mask: got %h expected 0", readdata); end
        address = 3'd3; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_cap: got %h expected 0", readdata); end
    endtask

    task automatic test_data_out();
        do_write(3'd0, 32'hFFFF_FF3C);
        total++; if (out_port !== 8'h3C) begin bad++; $display("[TB] FAIL wr_data_out: got %h expected 3c", out_port); end
        address = 3'd0; #1;
        total++; if (readdata !== 32'h0000_003C) begin bad++; $display("[TB] FAIL rd_data_out: got %h expected 0000003c", readdata); end
    endtask

    task automatic test_set_clear();
        do_write(3'd4, 32'h0000_0081);
        total++; if (out_port !== 8'hBD) begin bad++; $display("[TB] FAIL outset: got %h expected bd", out_port); end
        do_write(3'd5, 32'h0000_000C);
        total++; if (out_port !== 8'hB1) begin bad++; $display("[TB] FAIL outclear: got %h expected b1", out_port); end
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rd_outclear: got %h expected 0", readdata); end
        address = 3'd4; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rd_outset: got %h expected 0", readdata); end
        do_write(3'd6, 32'h0000_00FF);
        total++; if (out_port !== 8'hB1) begin bad++; $display("[TB] FAIL reserved_wr: got %h expected b1", out_port); end
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL reserved_rd: got %h expected 0", readdata); end
    endtask

    task automatic test_sync_edge();
`ifdef FINAL385_PIO_IRQ_EN
        do_write(3'd2, 32'h0000_0004);
        address = 3'd2; #1;
        total++; if (readdata !== 32'h0000_0004) begin bad++; $display("[TB] FAIL rd_mask: got %h expected 00000004", readdata); end
`endif
        @(negedge clk);
        in_port = 8'h04;
        address = 3'd1;
        tick();
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL sync_1edge: got %h expected 0", readdata); end
        tick();
        total++; if (readdata !== 32'h0000_0004) begin bad++; $display("[TB] FAIL sync_2edge: got %h expected 00000004", readdata); end
`ifdef FINAL385_PIO_IRQ_EN
        address = 3'd3; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL cap_2edge: got %h expected 0", readdata); end
        tick();
        total++; if (readdata !== 32'h0000_0004) begin bad++; $display("[TB] FAIL cap_3edge: got %h expected 00000004", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_early: got %b expected 0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set: got %b expected 1", irq); end
`else
        tick();
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_off_sync: got %b expected 0", irq); end
`endif
    endtask

`ifdef FINAL385_PIO_IRQ_EN
    task automatic test_w1c_set_wins();
        do_write(3'd3, 32'h0000_0004);
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL w1c_clear: got %h expected 0", readdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_hold: got %b expected 1", irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_drop: got %b expected 0", irq); end
        @(negedge clk);
        in_port = 8'h00;
        repeat (4) tick();
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL falling_ignored: got %h expected 0", readdata); end
        @(negedge clk);
        in_port = 8'h04;
        @(posedge clk);
        @(posedge clk);
        do_write(3'd3, 32'h0000_0004);
        total++; if (readdata !== 32'h0000_0004) begin bad++; $display("[TB] FAIL set_wins: got %h expected 00000004", readdata); end
        do_write(3'd3, 32'h0000_0004);
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL w1c_noedge: got %h expected 0", readdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_lag: got %b expected 1", irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared: got %b expected 0", irq); end
    endtask
`else
    task automatic test_irq_disabled();
        do_write(3'd2, 32'h0000_00FF);
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL off_rd2: got %h expected 0", readdata); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_port = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            address = 3'd3; #1;
            total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL off_rd3: got %h expected 0", readdata); end
            total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL off_irq: got %b expected 0", irq); end
        end
        do_write(3'd3, 32'h0000_00FF);
        address = 3'd2; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL off_rd2_end: got %h expected 0", readdata); end
    endtask
`endif

    task automatic test_reset_mid_write();
        @(negedge clk);
        in_port = 8'hFF;
        repeat (5) tick();
        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'h0000_0012;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        total++; if (out_port !== 8'hA5) begin bad++; $display("[TB] FAIL rst_out: got %h expected a5", out_port); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq: got %b expected 0", irq); end
        address = 3'd1; #1;
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_data_in: got %h expected 0", readdata); end
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        #1;
        total++; if (out_port !== 8'hA5) begin bad++; $display("[TB] FAIL rst_discard: got %h expected a5", out_port); end
        address = 3'd3;
        tick();
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_cap1: got %h expected 0", readdata); end
        tick();
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_cap2: got %h expected 0", readdata); end
        address = 3'd1; #1;
        total++; if (readdata !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL rst_data_in2: got %h expected 000000ff", readdata); end
        address = 3'd3;
        tick();
`ifdef FINAL385_PIO_IRQ_EN
        total++; if (readdata !== 32'h0000_00FF) begin bad++; $display("[TB] FAIL rst_cap3: got %h expected 000000ff", readdata); end
`else
        total++; if (readdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_cap3_off: got %h expected 0", readdata); end
`endif
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_irq_masked: got %b expected 0", irq); end
    endtask

    initial begin
        $display("[TB] starting final385_soc_pio_gen2 bench");
        test_reset();
        test_data_out();
        test_set_clear();
        test_sync_edge();
`ifdef FINAL385_PIO_IRQ_EN
        test_w1c_set_wins();
`else
        test_irq_disabled();
`endif
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/final385_soc_pio_gen2.md
FINAL385_SOC_PIO_GEN2 -- requirements
Module: final385_soc_pio_gen2

Interface
REQ-001 Parameter WIDTH, default 2, port width in bits; legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, value loaded into DATA_OUT on reset; truncated to WIDTH bits.
REQ-003 Parameter EDGE_TYPE, default 0, edge detected on in_port: 0 rising, 1 falling, 2 any.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-009 writedata  input  32  write data; bits above WIDTH are ignored.
REQ-010 readdata  output  32  read data, zero-extended above WIDTH.
REQ-011 in_port  input  WIDTH  asynchronous external inputs.
REQ-012 out_port  output  WIDTH  output register value.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 The register map SHALL be: 0 DATA_OUT R/W; 1 DATA_IN R; 2 IRQ_MASK R/W; 3 EDGE_CAP R/W1C; 4 OUTSET W; 5 OUTCLEAR W; 6-7 reserved, read 0, writes ignored.
REQ-015 readdata SHALL be combinational from address (read latency 0), independent of chipselect; write-only addresses 4 and 5 read 0.
REQ-016 A write to 0 SHALL load DATA_OUT <= writedata[WIDTH-1:0] on the next clock edge.
REQ-017 A write to 4 SHALL apply DATA_OUT <= DATA_OUT | wd; a write to 5 SHALL apply DATA_OUT <= DATA_OUT & ~wd; one cycle latency.
REQ-018 out_port SHALL equal DATA_OUT directly, with no extra register stage.
REQ-019 in_port SHALL pass through a 2-flop synchronizer (s1, s2); DATA_IN reads s2, so an in_port change is visible 2 clock edges later.
REQ-020 A third register s3 SHALL hold the previous s2; edge is s2&~s3 (rising), ~s2&s3 (falling), or s2^s3 (any), per bit.
REQ-021 A detected edge SHALL set the corresponding EDGE_CAP bit on the same clock edge that s3 updates.
REQ-022 A write to 3 SHALL clear every EDGE_CAP bit written as 1; bits written as 0 are unchanged.
REQ-023 If an edge and a clear hit the same bit in the same cycle, set SHALL win.
REQ-024 irq SHALL be registered: irq <= |(EDGE_CAP & IRQ_MASK), one cycle after the cause.
REQ-025 A write to 2 SHALL load IRQ_MASK <= wd; the new mask affects irq one cycle later.

Reset
REQ-026 Asserting reset SHALL immediately set DATA_OUT=RESET_VALUE, IRQ_MASK=0, EDGE_CAP=0, irq=0, and s1/s2/s3=0.
REQ-027 If reset is asserted in the middle of an access, the access SHALL be discarded; a spurious edge SHALL NOT be captured on the first cycles after reset is released while s2/s3 settle from 0 (EDGE_CAP stays 0 for 2 cycles after deassertion).

Configuration
REQ-028 Macro FINAL385_PIO_IRQ_EN: when defined, the edge-capture, IRQ_MASK, EDGE_CAP and irq logic SHALL be compiled in as specified.
REQ-029 When FINAL385_PIO_IRQ_EN is undefined, s3, EDGE_CAP, IRQ_MASK and the irq register SHALL be absent; addresses 2 and 3 read 0 and ignore writes; irq is tied 0; the port list is unchanged.

Verification (WIDTH=8, RESET_VALUE=8'hA5, EDGE_TYPE=0, macro defined unless stated)
REQ-030 Release reset -> out_port=8'hA5, readdata@0=32'h000000A5, irq=0; write 32'hFFFF_FF3C to address 0 -> out_port=8'h3C after 1 cycle.
REQ-031 DATA_OUT=8'h3C; write 8'h81 to address 4, then 8'h0C to address 5 -> out_port=8'hBD, then 8'hB1.
REQ-032 in_port 8'h00->8'h04 -> DATA_IN=8'h04 after 2 edges; EDGE_CAP=8'h04 after 3 edges; with IRQ_MASK=8'h04, irq=1 one cycle later.
REQ-033 EDGE_CAP=8'h04; write 8'h04 to address 3 on the cycle bit 2 sees a new rising edge -> EDGE_CAP stays 8'h04; write again with no edge -> 8'h00 and irq=0 next cycle.
REQ-034 Assert reset for 1 cycle mid-write with in_port=8'hFF held -> all registers at reset values; EDGE_CAP=0 for 2 cycles after release, then 8'hFF.
REQ-035 Macro undefined: write 8'hFF to address 2, toggle in_port -> readdata@2=0, readdata@3=0, irq=0 throughout.
